// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter shared by instruction fetch and load/store.
// Data wins by default; a fetch that has lost STARVE_MAX times in a row is forced through.
module dmem_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_misalign,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [5:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR_D} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [SW-1:0] r_starve;
    logic [1:0]  r_ldOff;
    logic [1:0]  r_ldSize;
    logic        r_ldUns;

    logic        w_misalign;
    logic        w_dOk;
    logic        w_ifWin;
    logic        w_dWin;
    logic        w_dIssue;
    logic [3:0]  w_storeBe;
    logic [31:0] w_storeData;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldData;
    logic        w_unused;

    assign w_unused = ^{if_addr[31:8], if_addr[1:0], d_addr[31:8]};

    // A misaligned data request never touches memory, so it cannot block a pending fetch.
    assign w_misalign = d_req && (((d_size == 2'b01) && d_addr[0]) ||
                                  (d_size[1] && (d_addr[1:0] != 2'b00)));
    assign w_dOk      = d_req && !w_misalign;
    assign w_ifWin    = if_req && (!w_dOk || (r_starve == STARVE_LIM));
    assign w_dWin     = d_req && (w_misalign || !w_ifWin);
    assign w_dIssue   = w_dWin && !w_misalign;

    always_comb begin
        w_storeBe   = 4'b1111;
        w_storeData = d_wdata;
        case (d_size)
            2'b00: begin
                w_storeBe   = 4'b0001 << d_addr[1:0];
                w_storeData = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                w_storeBe   = d_addr[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = IDLE;
        if (w_ifWin) begin
            w_nextState = RD_I;
        end else if (w_dIssue) begin
            w_nextState = d_we ? WR_D : RD_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_ldOff  <= 2'b00;
            r_ldSize <= 2'b00;
            r_ldUns  <= 1'b0;
        end else begin
            if (!if_req || w_ifWin) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_LIM) begin
                r_starve <= r_starve + SW'(1);
            end
            if (w_dIssue && !d_we) begin
                r_ldOff  <= d_addr[1:0];
                r_ldSize <= d_size;
                r_ldUns  <= d_unsigned;
            end
        end
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_ldOff)
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            2'b11:   w_byte = mem_rdata[31:24];
            default: ;
        endcase
        w_half   = r_ldOff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_ldData = mem_rdata;
        case (r_ldSize)
            2'b00:   w_ldData = {{24{w_byte[7] & ~r_ldUns}}, w_byte};
            2'b01:   w_ldData = {{16{w_half[15] & ~r_ldUns}}, w_half};
            default: ;
        endcase
    end

    // Grants and memory controls are forced low while reset is held so nothing issues.
    always_comb begin
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        d_misalign = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 6'd0;
        mem_wdata  = 32'd0;
        if (rst_n) begin
            if_gnt     = w_ifWin;
            d_gnt      = w_dWin;
            d_misalign = w_dWin && w_misalign;
            if (w_ifWin) begin
                mem_en   = 1'b1;
                mem_be   = 4'b1111;
                mem_addr = if_addr[7:2];
            end else if (w_dIssue) begin
                mem_en   = 1'b1;
                mem_addr = d_addr[7:2];
                mem_be   = 4'b1111;
                if (d_we) begin
                    mem_we    = 1'b1;
                    mem_be    = w_storeBe;
                    mem_wdata = w_storeData;
                end
            end
        end
        if_rvalid = (r_state == RD_I);
        if_rdata  = (r_state == RD_I) ? mem_rdata : 32'd0;
        d_rvalid  = (r_state == RD_D);
        d_rdata   = (r_state == RD_D) ? w_ldData : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors check grants and memory controls,
// and expected read responses are queued with their due cycle for an independent monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [1:0]  d_size = 2'b00;
    logic        d_gnt, d_rvalid, d_misalign;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [64];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t dq[$];
    exp_t iq[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    dmem_arbiter #(.STARVE_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_misalign(d_misalign),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Synchronous single-port memory: byte-lane writes, read data the cycle after issue.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    function automatic void compare(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: a queued response must appear exactly on its due cycle; any other rvalid is spurious.
    always @(negedge clk) begin
        if (dq.size() > 0 && dq[0].due == cycle) begin
            compare("d_rvalid", {31'd0, d_rvalid}, 32'd1);
            compare("d_rdata", d_rdata, dq[0].data);
            void'(dq.pop_front());
        end else if (d_rvalid) begin
            compare("d_rvalid unexpected", {31'd0, d_rvalid}, 32'd0);
        end
        if (iq.size() > 0 && iq[0].due == cycle) begin
            compare("if_rvalid", {31'd0, if_rvalid}, 32'd1);
            compare("if_rdata", if_rdata, iq[0].data);
            void'(iq.pop_front());
        end else if (if_rvalid) begin
            compare("if_rvalid unexpected", {31'd0, if_rvalid}, 32'd0);
        end
    end

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dReq, input logic dWe, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata, input logic [1:0] dSize,
                                 input logic dUns);
        if_req     = ifReq;
        if_addr    = ifAddr;
        d_req      = dReq;
        d_we       = dWe;
        d_addr     = dAddr;
        d_wdata    = dWdata;
        d_size     = dSize;
        d_unsigned = dUns;
    endtask

    task automatic checkOutput(input string tag, input logic eIf, input logic eD,
                               input logic eMis, input logic eEn, input logic eWe,
                               input logic [3:0] eBe, input logic [5:0] eAddr,
                               input logic [31:0] eWdata,
                               input logic pushD, input logic [31:0] dData,
                               input logic pushI, input logic [31:0] iData);
        exp_t e;
        @(negedge clk);
        compare({tag, " if_gnt"}, {31'd0, if_gnt}, {31'd0, eIf});
        compare({tag, " d_gnt"}, {31'd0, d_gnt}, {31'd0, eD});
        compare({tag, " d_misalign"}, {31'd0, d_misalign}, {31'd0, eMis});
        compare({tag, " mem_en"}, {31'd0, mem_en}, {31'd0, eEn});
        if (eEn) begin
            compare({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, eWe});
            compare({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, eBe});
            compare({tag, " mem_addr"}, {26'd0, mem_addr}, {26'd0, eAddr});
        end
        if (eWe) compare({tag, " mem_wdata"}, mem_wdata, eWdata);
        if (pushD) begin
            e.data = dData;
            e.due  = cycle + 1;
            dq.push_back(e);
        end
        if (pushI) begin
            e.data = iData;
            e.due  = cycle + 1;
            iq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        compare({tag, " if_gnt"}, {31'd0, if_gnt}, 32'd0);
        compare({tag, " d_gnt"}, {31'd0, d_gnt}, 32'd0);
        compare({tag, " mem_en"}, {31'd0, mem_en}, 32'd0);
        compare({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        compare({tag, " mem_be"}, {28'd0, mem_be}, 32'd0);
        compare({tag, " if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        compare({tag, " d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
        compare({tag, " if_rdata"}, if_rdata, 32'd0);
        compare({tag, " d_rdata"}, d_rdata, 32'd0);
        compare({tag, " d_misalign"}, {31'd0, d_misalign}, 32'd0);
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        checkOutput(tag, 0, 0, 0, 0, 0, 4'h0, 6'd0, 32'd0, 0, 32'd0, 0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;

        // Reset held with both requesters active: nothing may be granted or issued.
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 32'h08, 32'h1111_2222, 2'b10, 1'b0);
        #3;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        checkResetOutputs("reset after edge");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("idle after reset");

        // Word store then load of the same address, back to back.
        applyStimulus(0, 0, 1, 1, 32'h08, 32'hDEAD_BEEF, 2'b10, 0);
        checkOutput("sw 0x08", 0, 1, 0, 1, 1, 4'hF, 6'd2, 32'hDEAD_BEEF, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h08, 32'd0, 2'b10, 0);
        checkOutput("lw 0x08", 0, 1, 0, 1, 0, 4'hF, 6'd2, 0, 1, 32'hDEAD_BEEF, 0, 0);

        // Sub-word loads with sign and zero extension.
        applyStimulus(0, 0, 1, 1, 32'h10, 32'h8000_80F0, 2'b10, 0);
        checkOutput("sw 0x10", 0, 1, 0, 1, 1, 4'hF, 6'd4, 32'h8000_80F0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h11, 32'd0, 2'b00, 0);
        checkOutput("lb 0x11", 0, 1, 0, 1, 0, 4'hF, 6'd4, 0, 1, 32'hFFFF_FF80, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h10, 32'd0, 2'b00, 1);
        checkOutput("lbu 0x10", 0, 1, 0, 1, 0, 4'hF, 6'd4, 0, 1, 32'h0000_00F0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h12, 32'd0, 2'b01, 0);
        checkOutput("lh 0x12", 0, 1, 0, 1, 0, 4'hF, 6'd4, 0, 1, 32'hFFFF_8000, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h12, 32'd0, 2'b01, 1);
        checkOutput("lhu 0x12", 0, 1, 0, 1, 0, 4'hF, 6'd4, 0, 1, 32'h0000_8000, 0, 0);

        // Sub-word stores: lane enables and replicated data, then read back.
        applyStimulus(0, 0, 1, 1, 32'h07, 32'h1234_56AB, 2'b00, 0);
        checkOutput("sb 0x07", 0, 1, 0, 1, 1, 4'b1000, 6'd1, 32'hABAB_ABAB, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'h0E, 32'hAAAA_5678, 2'b01, 0);
        checkOutput("sh 0x0E", 0, 1, 0, 1, 1, 4'b1100, 6'd3, 32'h5678_5678, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h04, 32'd0, 2'b10, 0);
        checkOutput("lw 0x04", 0, 1, 0, 1, 0, 4'hF, 6'd1, 0, 1, 32'hABDE_0001, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0C, 32'd0, 2'b10, 0);
        checkOutput("lw 0x0C", 0, 1, 0, 1, 0, 4'hF, 6'd3, 0, 1, 32'h5678_0003, 0, 0);

        // Size 11 behaves as word; upper address bits wrap.
        applyStimulus(0, 0, 1, 0, 32'hFFFF_FF10, 32'd0, 2'b11, 0);
        checkOutput("lw size11 wrap", 0, 1, 0, 1, 0, 4'hF, 6'd4, 0, 1, 32'h8000_80F0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'hFFFF_0013, 32'd0, 2'b00, 1);
        checkOutput("lbu 0x13 wrap", 0, 1, 0, 1, 0, 4'hF, 6'd4, 0, 1, 32'h0000_0080, 0, 0);
        idle("idle 1");

        // Both requesters held: three data grants, then the starved fetch wins.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 32'hFFFF_FF23, 1, 0, 32'h08, 32'd0, 2'b10, 0);
            if (k % 4 == 3)
                checkOutput("starve fetch", 1, 0, 0, 1, 0, 4'hF, 6'd8, 0, 0, 0, 1, 32'hC0DE_0008);
            else
                checkOutput("starve data", 0, 1, 0, 1, 0, 4'hF, 6'd2, 0, 1, 32'hDEAD_BEEF, 0, 0);
        end
        idle("idle 2");

        // Misaligned accesses: granted with a fault pulse, no memory access, no load data.
        applyStimulus(1, 32'h0C, 1, 0, 32'h06, 32'd0, 2'b10, 0);
        checkOutput("misaligned lw + fetch", 1, 1, 1, 1, 0, 4'hF, 6'd3, 0, 0, 0, 1, 32'h5678_0003);
        applyStimulus(0, 0, 1, 0, 32'h01, 32'd0, 2'b01, 0);
        checkOutput("misaligned lh", 0, 1, 1, 0, 0, 4'h0, 6'd0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'h02, 32'hFFFF_FFFF, 2'b10, 0);
        checkOutput("misaligned sw", 0, 1, 1, 0, 0, 4'h0, 6'd0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h00, 32'd0, 2'b10, 0);
        checkOutput("lw 0x00 untouched", 0, 1, 0, 1, 0, 4'hF, 6'd0, 0, 1, 32'hC0DE_0000, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h02, 32'd0, 2'b01, 0);
        checkOutput("lh 0x02 aligned", 0, 1, 0, 1, 0, 4'hF, 6'd0, 0, 1, 32'hFFFF_C0DE, 0, 0);
        idle("idle misalign cleared");

        // Reset pulsed after a load grant but before its issuing edge: no response may follow.
        applyStimulus(0, 0, 1, 0, 32'h08, 32'd0, 2'b10, 0);
        @(negedge clk);
        compare("pre-reset d_gnt", {31'd0, d_gnt}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("reset mid-read");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("idle after reset 2a");
        idle("idle after reset 2b");
        applyStimulus(1, 32'h20, 0, 0, 32'd0, 32'd0, 2'b00, 0);
        checkOutput("fetch after reset", 1, 0, 0, 1, 0, 4'hF, 6'd8, 0, 0, 0, 1, 32'hC0DE_0008);
        idle("final idle");
        idle("drain");

        compare("d queue drained", dq.size(), 32'd0);
        compare("if queue drained", iq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
